// File: rtl/ser_frame_pkg.sv
// ser_frame_pkg: state encoding and line levels shared by the frame transmitter and receiver
package ser_frame_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
endpackage

// File: rtl/ser_frame_tx_bit_timer.sv
// bit_timer: counts clocks within a serial bit and flags the last one; held clear while disabled
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic bit_end
);
   localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
   logic [TW-1:0] timer;
   assign bit_end = en && timer == TW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) timer <= '0;
      else     timer <= (!en || bit_end) ? '0 : timer + 1'b1;
   end
endmodule

// File: rtl/ser_frame_tx.sv
// ser_frame_tx: parallel-to-serial frame transmitter (start bit, LSB-first data, stop bit)
module ser_frame_tx
   import ser_frame_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              q,
   output logic              busy,
   output logic              done
);
   localparam int CW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   if (DATA_W < 1 || CLKS_PER_BIT < 1) begin : g_bad_params
      $error("ser_frame_tx: DATA_W and CLKS_PER_BIT must be >= 1");
   end
   state_t            state, state_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [CW-1:0]     bit_cnt, bit_cnt_n;
   logic              q_n, busy_n, rdy_n, done_n, bit_end;
   bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk(clk),
      .rst(rst),
      .en(state != ST_IDLE),
      .bit_end(bit_end)
   );
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_cnt_n = bit_cnt;
      q_n       = q;
      busy_n    = busy;
      rdy_n     = din_ready;
      done_n    = 1'b0;
      case (state)
         ST_IDLE: if (din_valid) begin
            state_n   = ST_START;
            shreg_n   = din;
            bit_cnt_n = '0;
            q_n       = START_LEVEL;
            busy_n    = 1'b1;
            rdy_n     = 1'b0;
         end
         ST_START: if (bit_end) begin
            state_n = ST_DATA;
            q_n     = shreg[0];
         end
         ST_DATA: if (bit_end) begin
            if (bit_cnt == CW'(DATA_W - 1)) begin
               state_n = ST_STOP;
               q_n     = IDLE_LEVEL;
            end else begin
               shreg_n   = shreg >> 1;
               bit_cnt_n = bit_cnt + 1'b1;
               q_n       = shreg_n[0];
            end
         end
         ST_STOP: if (bit_end) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
            busy_n    = 1'b0;
            rdy_n     = 1'b1;
            done_n    = 1'b1;
         end
         default: state_n = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         q         <= IDLE_LEVEL;
         busy      <= 1'b0;
         din_ready <= 1'b1;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         bit_cnt   <= bit_cnt_n;
         q         <= q_n;
         busy      <= busy_n;
         din_ready <= rdy_n;
         done      <= done_n;
      end
   end
endmodule

// File: tb/tb_ser_frame_tx.sv
// tb_ser_frame_tx: table-driven and randomized checks of ser_frame_tx against a frame-level model
module tb_ser_frame_tx;
   localparam int C  = 4;
   localparam int FL = 10 * C;
   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] din = '0;
   logic       din_valid = 1'b0;
   logic       din_ready, q, busy, done;
   logic [3:0] din2 = '0;
   logic       v2 = 1'b0;
   logic       rdy2, q2, busy2, done2;
   int         n_cmp = 0, n_bad = 0;
   bit         m_act, m_done;
   int         m_k, cyc_n, done_cyc, rise_cyc;
   logic [9:0] m_f, cap, last_frame;
   logic       prev_busy = 1'b0;

   typedef struct {
      logic [7:0] word;
      bit         b2b;
      bit         poke;
      logic [9:0] frame;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   ser_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .q(q), .busy(busy), .done(done)
   );
   ser_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut2 (
      .clk(clk), .rst(rst), .din(din2), .din_valid(v2),
      .din_ready(rdy2), .q(q2), .busy(busy2), .done(done2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // The model tracks only "in a frame, k cycles since accept"; line level is frame bit k/C.
   task automatic cyc();
      @(posedge clk);
      cyc_n++;
      if (rst) begin
         m_act = 0; m_done = 0; m_k = 0;
      end else begin
         m_done = 0;
         if (!m_act) begin
            if (din_valid) begin m_act = 1; m_k = 0; m_f = {1'b1, din, 1'b0}; end
         end else begin
            m_k++;
            if (m_k == FL) begin m_act = 0; m_done = 1; end
         end
      end
      #1;
      chk($sformatf("outs@%0d", cyc_n), 32'({q, busy, din_ready, done}),
          32'({m_act ? m_f[m_k / C] : 1'b1, m_act, !m_act, m_done}));
      if (m_act && m_k % C == C / 2) cap[m_k / C] = q;
      if (done) begin last_frame = cap; done_cyc = cyc_n; end
      if (busy && !prev_busy) rise_cyc = cyc_n;
      prev_busy = busy;
   endtask

   task automatic send(input logic [7:0] w, input bit b2b, input logic [7:0] nxt, input bit poke);
      int t;
      din = w; din_valid = 1'b1; t = 0;
      do begin cyc(); t++; end while (!(m_act && m_k == 0) && t < 200);
      if (t >= 200) chk("accept_timeout", 32'(t), 32'(0));
      din = b2b ? nxt : 8'($urandom); din_valid = b2b; t = 0;
      while (!done && t < 200) begin
         cyc(); t++;
         if (poke && m_act && m_k == 14) begin din_valid = 1'b1; din = 8'hFF; end
         else if (poke && m_act && m_k == 15) begin din_valid = b2b; din = b2b ? nxt : din; end
      end
      if (t >= 200) chk("done_timeout", 32'(t), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] exp2;
      logic [7:0] rw[41];
      int         pd;
      tbl[0] = '{8'hA5, 1, 0, 10'h34A};
      tbl[1] = '{8'h3C, 0, 0, 10'h278};
      tbl[2] = '{8'h5A, 0, 1, 10'h2B4};
      tbl[3] = '{8'h00, 0, 0, 10'h200};
      repeat (3) cyc();
      chk("reset_state", 32'({q, busy, din_ready, done}), 32'(4'b1010));
      rst = 1'b0;
      repeat (3) cyc();
      for (int i = 0; i < 4; i++) begin
         pd = done_cyc;
         send(tbl[i].word, tbl[i].b2b, i < 3 ? tbl[i + 1].word : 8'h00, tbl[i].poke);
         chk($sformatf("frame%0d", i), 32'(last_frame), 32'(tbl[i].frame));
         chk($sformatf("len%0d", i), 32'(done_cyc - rise_cyc), 32'(FL));
         if (i > 0 && tbl[i - 1].b2b) chk("b2b_gap", 32'(rise_cyc - pd), 32'(1));
      end
      repeat (4) cyc();
      // abort a frame during data bit 3, between clock edges
      din = 8'hC3; din_valid = 1'b1;
      for (int t = 0; t < 10 && !(m_act && m_k == 0); t++) cyc();
      din_valid = 1'b0;
      for (int t = 0; t < 40 && m_k != 17; t++) cyc();
      #2 rst = 1'b1;
      #1 chk("rst_async", 32'({q, busy, din_ready, done}), 32'(4'b1010));
      repeat (2) cyc();
      rst = 1'b0;
      repeat (45) cyc();
      send(8'h01, 0, 8'h00, 0);
      chk("frame_after_rst", 32'(last_frame), 32'(10'h202));
      for (int i = 0; i < 41; i++) rw[i] = 8'($urandom);
      for (int i = 0; i < 40; i++) begin
         bit b = 1'($urandom_range(0, 1));
         send(rw[i], b, rw[i + 1], $urandom_range(0, 3) == 0);
         chk($sformatf("rand_frame%0d", i), 32'(last_frame), 32'({1'b1, rw[i], 1'b0}));
         if (!b) repeat ($urandom_range(0, 5)) begin din = 8'($urandom); cyc(); end
      end
      din_valid = 1'b0;
      repeat (5) cyc();
      exp2 = 6'b110010;
      din2 = 4'b1001; v2 = 1'b1;
      cyc();
      v2 = 1'b0; din2 = '0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("q2_k%0d", k), 32'({q2, done2, busy2}), 32'({exp2[k], 1'b0, 1'b1}));
         cyc();
      end
      chk("done2", 32'({q2, done2, busy2, rdy2}), 32'(4'b1101));
      cyc();
      chk("done2_pulse", 32'({done2, rdy2}), 32'(2'b01));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ser_frame_tx.md
Name: ser_frame_tx

Overview:
- Parallel-to-serial frame transmitter. Drives the serial bit stream sampled by the team's D flip-flop / shift-register receivers.
- Accepts one DATA_W-bit word per valid/ready handshake.
- Emits the word on q as one frame: start bit (0), data bits LSB first, stop bit (1). Each bit is held for CLKS_PER_BIT clocks.
- Sits between a local word source and a serial link; q idles high.

Parameters:
- DATA_W, 8, payload width in bits (>=1)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- din  input  DATA_W  word to transmit; sampled only on an accept edge
- din_valid  input  1  source has a word on din
- din_ready  output  1  block can accept a word; high only in IDLE
- q  output  1  serial line, registered; idle/stop = 1, start = 0
- busy  output  1  high from the accept edge until the frame completes
- done  output  1  one-cycle pulse when the stop bit finishes

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst assertion (also mid-frame): state=IDLE, q=1, din_ready=1, busy=0, done=0, shift register=0, timer=0, bit counter=0.
- States:
  - IDLE: waiting for a word.
  - START: q=0.
  - DATA: q = shift register bit 0.
  - STOP: q=1.
- Accept: a rising edge with din_valid=1 and din_ready=1.
  - Latch din into the shift register.
  - Go to START; q<=0, busy<=1, din_ready<=0 on that same edge.
  - q is therefore low in the first cycle after the accept edge.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - A bit ends when timer==CLKS_PER_BIT-1; the timer then wraps to 0.
  - When CLKS_PER_BIT=1, every cycle ends a bit.
- Transitions at bit end:
  - START -> DATA: q<=shreg[0].
  - DATA, bit_cnt<DATA_W-1: shift right, bit_cnt++, q<=next bit.
  - DATA, bit_cnt=DATA_W-1: -> STOP, q<=1.
  - STOP -> IDLE: busy<=0, din_ready<=1, done<=1 for exactly one cycle.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles. With the accept edge as E0, the return to IDLE and the done pulse occur at edge E0+(DATA_W+2)*CLKS_PER_BIT.
- Back-to-back words:
  - The next accept is possible at the edge after done rises, because din_ready is high in that cycle.
  - No extra idle-high bit is inserted beyond the stop bit and that one cycle.
- din_valid while busy: ignored; no state change.
- din changes after accept: no effect on the frame in flight.
- done and din_valid in the same cycle: legal; the accept happens at the next edge.
- Reset mid-frame: the frame is aborted; q returns to 1 asynchronously; no done pulse is generated.
- Widths:
  - bit_cnt: $clog2(DATA_W), minimum 1 bit.
  - timer: $clog2(CLKS_PER_BIT), minimum 1 bit.
  - Both counters wrap only through the explicit compare; no modular overflow is relied on.
- Parameter guard: DATA_W<1 or CLKS_PER_BIT<1 -> elaboration error.

Decomposition:
- Shared package ser_frame_pkg:
  - state encoding constants ST_IDLE, ST_START, ST_DATA, ST_STOP (2 bits)
  - IDLE_LEVEL=1'b1
  - START_LEVEL=1'b0
- The matching receiver reuses the same package.
- One sub-module, bit_timer:
  - Parameter CLKS_PER_BIT.
  - Inputs: clk, rst, en.
  - Output: bit_end.
  - Clears when en=0.

Test Plan:
- Reset: assert rst mid-simulation -> q=1, din_ready=1, busy=0, done=0 immediately, without waiting for a clock edge.
- Single word, DATA_W=8, CLKS_PER_BIT=4, din=8'hA5:
  - q holds, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - done pulses at edge E0+40.
  - busy is high for exactly 40 cycles.
- Back-to-back, din_valid held high with 8'hA5 then 8'h3C:
  - The second accept occurs one cycle after done.
  - The second frame's data bits are 0,0,1,1,1,1,0,0.
- Valid while busy: pulse din_valid with din=8'hFF during the DATA state -> frame bits unchanged, no second frame, din_ready stays 0.
- Reset mid-frame: assert rst during data bit 3 -> q=1 at once, no done pulse. A new word (8'h01) after reset transmits correctly.
- CLKS_PER_BIT=1, DATA_W=4, din=4'b1001: q sequence 0,1,0,0,1,1 on consecutive cycles; done at E0+6.
